mp_ifetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction cache. Owns the fetch PC and drives icache_req/icache_addr. Captures the cache word returned one cycle after each request into a small fetch buffer and presents {pc, instruction} to decode over a valid/ready handshake. Accepts redirects (branch/exception) that flush all fetched-but-unconsumed work.

---
 rtl/mp_ifetch_pkg.sv | 16 +
 rtl/mp_ifetch_if.sv | 33 +++
 rtl/mp_ifetch_fifo.sv | 72 +++++++
 rtl/mp_ifetch.sv | 115 +++++++++++
 tb/tb_mp_ifetch.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mp_ifetch_pkg.sv
// mp_ifetch shared types and widths.
// Fetch buffer entries pack the word address above the instruction.
package mp_ifetch_pkg;

  localparam int PC_W       = 30;
  localparam int INST_W     = 32;
  localparam int FB_ENTRY_W = PC_W + INST_W;

  localparam logic [PC_W-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fb_entry_t;

endpackage

// File: rtl/mp_ifetch_if.sv
// mp_ifetch bus bundle: icache request/return, redirect and decode handshake.
// master = fetch stage, slave = its environment.
interface mp_ifetch_if
  import mp_ifetch_pkg::*;
();

  logic              icache_req;
  logic [PC_W-1:0]   icache_addr;
  logic [INST_W-1:0] icache_data;
  logic              redirect_vld;
  logic [PC_W-1:0]   redirect_pc;
  logic              inst_vld;
  logic [INST_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_rdy;

  modport master (
    output icache_req, icache_addr,
    input  icache_data,
    input  redirect_vld, redirect_pc,
    output inst_vld, inst_data, inst_pc,
    input  inst_rdy
  );

  modport slave (
    input  icache_req, icache_addr,
    output icache_data,
    output redirect_vld, redirect_pc,
    input  inst_vld, inst_data, inst_pc,
    output inst_rdy
  );

endinterface

// File: rtl/mp_ifetch_fifo.sv
// ifetch_fifo: power-of-2 synchronous FIFO with registered head,
// occupancy count and a synchronous flush that beats push/pop.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 62
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      flush_i: begin
        wr_d  = '0;
        rd_d  = '0;
        cnt_d = '0;
      end
      default: begin
        if (push_i) wr_d = wr_q + 1'b1;
        if (do_pop) rd_d = rd_q + 1'b1;
        cnt_d = cnt_q + (AW+1)'(push_i)
                      - (AW+1)'(do_pop);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i)
      mem_q[wr_q] <= data_i;
  end

  // Upstream credit must keep pushes away from a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && push_i && !flush_i)
      assert (cnt_q < (AW+1)'(DEPTH));
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mp_ifetch.sv
// mp_ifetch: fetch PC, icache request and fetch buffer to decode.
// IFETCH_PERF_EN adds fetch/stall/flush performance counters.
module mp_ifetch
  import mp_ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              FB_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        sys_rst,
  mp_ifetch_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int CW = $clog2(FB_DEPTH) + 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ifpc_q, ifpc_d;
  logic            started_q;
  logic            infl_q, infl_d;
  logic            req;
  logic            pop;
  logic [CW-1:0]   count;
  logic [CW:0]     credit;
  fb_entry_t       head;
  fb_entry_t       push_ent;

  // Credit counts the in-flight word so a push never finds the buffer full.
  assign credit = {1'b0, count} + (CW+1)'(infl_q);
  assign req    = started_q && !bus.redirect_vld
               && (credit < (CW+1)'(FB_DEPTH));

  always_comb begin
    pc_d   = pc_q;
    infl_d = 1'b0;
    ifpc_d = ifpc_q;
    unique case (1'b1)
      bus.redirect_vld: pc_d = bus.redirect_pc;
      req: begin
        pc_d   = pc_q + 1'b1;
        infl_d = 1'b1;
        ifpc_d = pc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge sys_rst) begin
    if (sys_rst) begin
      pc_q      <= RESET_PC;
      ifpc_q    <= RESET_PC;
      infl_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ifpc_q    <= ifpc_d;
      infl_q    <= infl_d;
      started_q <= 1'b1;
    end
  end

  assign push_ent.pc   = ifpc_q;
  assign push_ent.inst = bus.icache_data;
  assign pop           = bus.inst_vld && bus.inst_rdy;

  ifetch_fifo #(
    .DEPTH (FB_DEPTH),
    .W     (FB_ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (sys_rst),
    .flush_i (bus.redirect_vld),
    .push_i  (infl_q && !bus.redirect_vld),
    .data_i  (push_ent),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.icache_req  = req;
  assign bus.icache_addr = pc_q;
  assign bus.inst_vld    = (count != '0);
  assign bus.inst_pc     = head.pc;
  assign bus.inst_data   = head.inst;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_q, stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge CLK or posedge sys_rst) begin
    if (sys_rst) begin
      fetch_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (req)
        fetch_q <= fetch_q + 1'b1;
      if (started_q && !bus.redirect_vld && !req)
        stall_q <= stall_q + 1'b1;
      if (bus.redirect_vld)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign perf_fetch_cnt = fetch_q;
  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_mp_ifetch.sv
// Bench for mp_ifetch: transaction model checked every cycle
// plus hand-computed latency, backpressure, redirect and wrap points.
module tb_mp_ifetch;

  localparam int          DEPTH = 4;
  localparam logic [29:0] RPC   = 30'h0;

  logic CLK = 1'b0;
  logic sys_rst;

  mp_ifetch_if bus();

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  mp_ifetch #(
    .RESET_PC (RPC),
    .FB_DEPTH (DEPTH)
  ) dut (
    .CLK     (CLK),
    .sys_rst (sys_rst),
    .bus     (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [29:0] a);
    return {2'b00, a};
  endfunction

  // icache: latch address on request, return word next cycle
  logic [29:0] lat_addr = '0;
  always @(posedge CLK)
    if (bus.icache_req) lat_addr <= bus.icache_addr;
  assign bus.icache_data = mem(lat_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: every issued request becomes an item ready 2 cycles later
  typedef struct {
    logic [29:0] pc;
    int          rdy;
  } item_t;

  item_t       q[$];
  logic [29:0] m_npc = RPC;
  bit          m_started = 0;
  int          m_cyc = 0;
  bit          exp_req, exp_vld;
  int unsigned m_fetch = 0, m_stall = 0, m_flush = 0;

  always @(negedge CLK) begin
    if (sys_rst) begin
      q.delete();
      m_started = 0;
      m_npc     = RPC;
      m_fetch   = 0;
      m_stall   = 0;
      m_flush   = 0;
      chk("rst_req", 64'(bus.icache_req), 64'(0));
      chk("rst_vld", 64'(bus.inst_vld), 64'(0));
`ifdef IFETCH_PERF_EN
      chk("rst_pfetch", 64'(perf_fetch_cnt), 64'(0));
      chk("rst_pflush", 64'(perf_flush_cnt), 64'(0));
`endif
    end else begin
      exp_req = m_started && !bus.redirect_vld
             && (q.size() < DEPTH);
      exp_vld = (q.size() != 0) && (q[0].rdy <= m_cyc);
      chk("m_req", 64'(bus.icache_req), 64'(exp_req));
      if (exp_req)
        chk("m_addr", 64'(bus.icache_addr), 64'(m_npc));
      chk("m_vld", 64'(bus.inst_vld), 64'(exp_vld));
      if (exp_vld) begin
        chk("m_pc", 64'(bus.inst_pc), 64'(q[0].pc));
        chk("m_data", 64'(bus.inst_data), 64'(mem(q[0].pc)));
      end
`ifdef IFETCH_PERF_EN
      chk("m_pfetch", 64'(perf_fetch_cnt), 64'(m_fetch));
      chk("m_pstall", 64'(perf_stall_cnt), 64'(m_stall));
      chk("m_pflush", 64'(perf_flush_cnt), 64'(16'(m_flush)));
`endif
      if (exp_req) m_fetch++;
      if (m_started && !bus.redirect_vld && !exp_req) m_stall++;
      if (bus.redirect_vld) m_flush++;
      if (bus.redirect_vld) begin
        q.delete();
        m_npc = bus.redirect_pc;
      end else begin
        if (exp_vld && bus.inst_rdy) void'(q.pop_front());
        if (exp_req) begin
          q.push_back('{m_npc, m_cyc + 2});
          m_npc = m_npc + 30'd1;
        end
      end
      m_started = 1;
    end
    m_cyc++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  initial begin
    sys_rst          = 1'b1;
    bus.inst_rdy     = 1'b1;
    bus.redirect_vld = 1'b0;
    bus.redirect_pc  = '0;
    repeat (2) step();

    // streaming from reset, cycle 0 = first cycle after release
    sys_rst = 1'b0;
    samp();
    chk("c0_req", 64'(bus.icache_req), 64'(0));
    chk("c0_vld", 64'(bus.inst_vld), 64'(0));
    step(); samp();
    chk("c1_req", 64'(bus.icache_req), 64'(1));
    chk("c1_addr", 64'(bus.icache_addr), 64'(0));
    step(); samp();
    chk("c2_addr", 64'(bus.icache_addr), 64'(1));
    chk("c2_vld", 64'(bus.inst_vld), 64'(0));
    step(); samp();
    chk("c3_vld", 64'(bus.inst_vld), 64'(1));
    chk("c3_pc", 64'(bus.inst_pc), 64'(0));
    chk("c3_data", 64'(bus.inst_data), 64'(0));
    step(); samp();
    chk("c4_pc", 64'(bus.inst_pc), 64'(1));
    repeat (15) step();

    // asynchronous reset mid-stream, then backpressure from cycle 0
    sys_rst      = 1'b1;
    bus.inst_rdy = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.inst_vld), 64'(0));
    chk("arst_req", 64'(bus.icache_req), 64'(0));
`ifdef IFETCH_PERF_EN
    chk("arst_pfetch", 64'(perf_fetch_cnt), 64'(0));
`endif
    step(); step();
    sys_rst = 1'b0;
    repeat (10) step();
    samp();
    chk("bp_req", 64'(bus.icache_req), 64'(0));
    chk("bp_vld", 64'(bus.inst_vld), 64'(1));
    chk("bp_pc", 64'(bus.inst_pc), 64'(0));
`ifdef IFETCH_PERF_EN
    chk("bp_pfetch", 64'(perf_fetch_cnt), 64'(4));
`endif
    step();
    bus.inst_rdy = 1'b1;
    repeat (12) step();

    // redirect with 3 buffered + 1 in flight (cycle 5 under backpressure)
    sys_rst = 1'b1;
    step(); step();
    sys_rst      = 1'b0;
    bus.inst_rdy = 1'b0;
    repeat (5) step();
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 30'h100;
    samp();
    chk("r0_req", 64'(bus.icache_req), 64'(0));
    chk("r0_vld", 64'(bus.inst_vld), 64'(1));
    step();
    bus.redirect_vld = 1'b0;
    samp();
    chk("r1_vld", 64'(bus.inst_vld), 64'(0));
    chk("r1_req", 64'(bus.icache_req), 64'(1));
    chk("r1_addr", 64'(bus.icache_addr), 64'(30'h100));
    step(); samp();
    chk("r2_vld", 64'(bus.inst_vld), 64'(0));
    step(); samp();
    chk("r3_vld", 64'(bus.inst_vld), 64'(1));
    chk("r3_pc", 64'(bus.inst_pc), 64'(30'h100));
    step();
    bus.inst_rdy = 1'b1;
    repeat (5) step();

    // back-to-back redirects, last wins
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 30'h200;
    step();
    bus.redirect_pc  = 30'h300;
    step();
    bus.redirect_vld = 1'b0;
    samp();
    chk("bb_addr", 64'(bus.icache_addr), 64'(30'h300));
    step(); samp();
    chk("bb_vld3", 64'(bus.inst_vld), 64'(0));
    step(); samp();
    chk("bb_pc", 64'(bus.inst_pc), 64'(30'h300));
    repeat (4) step();

    // pc wrap
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 30'h3FFFFFFF;
    step();
    bus.redirect_vld = 1'b0;
    samp();
    chk("w_addr0", 64'(bus.icache_addr), 64'(30'h3FFFFFFF));
    step(); samp();
    chk("w_addr1", 64'(bus.icache_addr), 64'(0));
    step(); samp();
    chk("w_pc0", 64'(bus.inst_pc), 64'(30'h3FFFFFFF));
    step(); samp();
    chk("w_pc1", 64'(bus.inst_pc), 64'(0));
    chk("w_data1", 64'(bus.inst_data), 64'(0));
    step();

    // mixed backpressure and redirects, checked by the model
    repeat (300) begin
      step();
      bus.inst_rdy     = ($urandom_range(0, 3) != 0);
      bus.redirect_vld = ($urandom_range(0, 19) == 0);
      bus.redirect_pc  = 30'($urandom);
    end
    bus.redirect_vld = 1'b0;
    bus.inst_rdy     = 1'b1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
